// File: rtl/phase_pkg.sv
// phase_pkg: controller state encoding, fault codes and a small sizing helper
package phase_pkg;
  typedef enum logic [1:0] {WAIT, ARM, RUN, LOCK} state_t;
  typedef logic [1:0] fcode_t;
  localparam fcode_t FC_NONE    = 2'd0;
  localparam fcode_t FC_MISSING = 2'd1;
  localparam fcode_t FC_FREQ    = 2'd2;
  localparam fcode_t FC_ROT     = 2'd3;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/period_meter.sv
// period_meter: R-phase rising-edge period measurement in enable ticks with range qualification
module period_meter #(
  parameter int PW      = 16,
  parameter int PER_MIN = 18,
  parameter int PER_MAX = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          rdbphase,
  output logic [PW-1:0] period,
  output logic          period_valid
);
  localparam logic [PW-1:0] CNT_SAT = '1;
  localparam logic [PW-1:0] PMIN = PW'(PER_MIN);
  localparam logic [PW-1:0] PMAX = PW'(PER_MAX);
  if (PER_MAX >= (1 << PW) - 1 || PER_MIN > PER_MAX) begin : g_bad_cfg
    $error("period_meter: need PER_MIN <= PER_MAX < 2**PW-1");
  end
  logic rdb_q, cap_q, rise;
  logic [PW-1:0] per_cnt, per_inc;
  assign rise = rdbphase & ~rdb_q;
  assign per_inc = per_cnt + PW'(enable & (per_cnt != CNT_SAT));
  // count ticks between rises; qualify the captured period one cycle later, drop it early on a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdb_q <= 1'b0;
      cap_q <= 1'b0;
      per_cnt <= '0;
      period <= '0;
      period_valid <= 1'b0;
    end else begin
      rdb_q <= rdbphase;
      cap_q <= rise;
      per_cnt <= rise ? '0 : per_inc;
      if (rise) period <= per_inc;
      if (cap_q) period_valid <= period >= PMIN && period <= PMAX;
      else if (per_cnt > PMAX) period_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/phase_fault_ctl.sv
// phase_fault_ctl: supply qualification, relay on-delay/run/lockout sequencing and latched fault code; define PHASE_ROT_CHECK_EN to treat reverse rotation as a fault
module phase_fault_ctl
  import phase_pkg::*;
#(
  parameter int PW          = 16,
  parameter int PER_MIN     = 18,
  parameter int PER_MAX     = 22,
  parameter int ON_DLY      = 3000,
  parameter int RESTART_DLY = 5000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          rotation,
  input  logic          missing,
  input  logic          rdbphase,
  output logic          relay_on,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [PW-1:0] period,
  output logic          period_valid
);
  localparam int TW = $clog2(max2(ON_DLY, RESTART_DLY));
  localparam logic [TW-1:0] ON_END = TW'(ON_DLY - 1);
  localparam logic [TW-1:0] RS_END = TW'(RESTART_DLY - 1);
  state_t state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  fcode_t code_n;
  logic rot_fault, healthy;
  period_meter #(.PW(PW), .PER_MIN(PER_MIN), .PER_MAX(PER_MAX)) u_meter (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .rdbphase(rdbphase),
    .period(period),
    .period_valid(period_valid)
  );
`ifdef PHASE_ROT_CHECK_EN
  assign rot_fault = rotation;
`else
  logic unused_rotation;
  assign unused_rotation = rotation;
  assign rot_fault = 1'b0;
`endif
  assign healthy = ~missing & period_valid & ~rot_fault;
  // next state, timer and fault code; a tick coinciding with entry into ARM or LOCK is counted there
  always_comb begin
    state_n = state;
    tmr_n = tmr;
    code_n = fault_code;
    case (state)
      WAIT: begin
        tmr_n = healthy ? TW'(enable) : '0;
        state_n = healthy ? ARM : WAIT;
      end
      ARM: begin
        state_n = !healthy ? WAIT : (enable && tmr == ON_END) ? RUN : ARM;
        tmr_n = (!healthy || (enable && tmr == ON_END)) ? '0 : tmr + TW'(enable);
      end
      RUN: begin
        state_n = healthy ? RUN : LOCK;
        tmr_n = healthy ? '0 : TW'(enable);
        code_n = healthy ? fault_code : missing ? FC_MISSING : rot_fault ? FC_ROT : FC_FREQ;
      end
      LOCK: begin
        state_n = (enable && tmr == RS_END) ? WAIT : LOCK;
        tmr_n = (enable && tmr == RS_END) ? '0 : tmr + TW'(enable);
        code_n = (enable && tmr == RS_END) ? FC_NONE : fault_code;
      end
    endcase
  end
  // state, timer and registered outputs derived from the destination state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT;
      tmr <= '0;
      relay_on <= 1'b0;
      fault <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
      relay_on <= state_n == RUN;
      fault <= state_n == LOCK;
      fault_code <= code_n;
    end
  end
endmodule

// File: tb/tb_phase_fault_ctl.sv
// tb_phase_fault_ctl: vector table, directed corner sequences and random run against a tick-level reference model
module tb_phase_fault_ctl;
  localparam int PW = 16;
  localparam int PER_MIN = 18;
  localparam int PER_MAX = 22;
  localparam int ON_DLY = 3000;
  localparam int RESTART_DLY = 5000;
  localparam int SAT = (1 << PW) - 1;
  localparam int M_WAIT = 0, M_ARM = 1, M_RUN = 2, M_LOCK = 3;
`ifdef PHASE_ROT_CHECK_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  typedef struct {
    int per;
    int exp_period;
    int exp_valid;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic rotation = 1'b0;
  logic missing = 1'b0;
  logic rdbphase = 1'b0;
  logic relay_on, fault, period_valid;
  logic [1:0] fault_code;
  logic [PW-1:0] period;
  int errors = 0;
  int checks = 0;
  int m_prev, m_since, m_period, m_pend, m_valid, m_mode, m_ticks, m_code;
  int ph_p = 20;
  int ph_acc = 19;
  bit en_all = 1'b0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  phase_fault_ctl dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .rotation(rotation),
    .missing(missing),
    .rdbphase(rdbphase),
    .relay_on(relay_on),
    .fault(fault),
    .fault_code(fault_code),
    .period(period),
    .period_valid(period_valid)
  );

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_since = 0; m_period = 0; m_pend = 0;
    m_valid = 0; m_mode = M_WAIT; m_ticks = 0; m_code = 0;
  endtask

  function automatic int m_healthy();
    return (!missing && m_valid != 0 && !(ROT && rotation)) ? 1 : 0;
  endfunction

  task automatic new_phase(input int p);
    ph_p = p;
    ph_acc = p - 1;
  endtask

  task automatic drive();
    enable = en_all ? 1'b1 : ($urandom_range(15, 0) != 0);
    if (enable && ph_p > 0) begin
      ph_acc = (ph_acc + 1) % ph_p;
      rdbphase = ph_acc < ph_p / 2;
    end
  endtask

  task automatic step();
    int rise, h, inc, n_valid;
    rise = (rdbphase && m_prev == 0) ? 1 : 0;
    h = m_healthy();
    inc = m_since + int'(enable);
    if (inc > SAT) inc = SAT;
    n_valid = m_pend != 0 ? int'(m_period >= PER_MIN && m_period <= PER_MAX)
                          : (m_since > PER_MAX ? 0 : m_valid);
    m_pend = rise;
    m_prev = int'(rdbphase);
    if (rise != 0) begin
      m_period = inc;
      m_since = 0;
    end else m_since = inc;
    m_valid = n_valid;
    case (m_mode)
      M_WAIT: if (h != 0) begin m_mode = M_ARM; m_ticks = int'(enable); end
      M_ARM: begin
        if (h == 0) begin
          m_mode = M_WAIT; m_ticks = 0;
        end else begin
          m_ticks += int'(enable);
          if (m_ticks == ON_DLY) begin m_mode = M_RUN; m_ticks = 0; end
        end
      end
      M_RUN: if (h == 0) begin
        m_mode = M_LOCK;
        m_ticks = int'(enable);
        m_code = missing ? 1 : (ROT && rotation) ? 3 : 2;
      end
      default: begin
        m_ticks += int'(enable);
        if (m_ticks == RESTART_DLY) begin m_mode = M_WAIT; m_ticks = 0; m_code = 0; end
      end
    endcase
    @(posedge clk);
    #1;
    chk("model", int'({relay_on, fault, fault_code, period_valid, period}),
        int'({m_mode == M_RUN, m_mode == M_LOCK, 2'(m_code), m_valid != 0, 16'(m_period)}));
  endtask

  function automatic bit reached(input int what);
    return what == 0 ? !fault : what == 1 ? relay_on : what == 2 ? fault : (m_mode == M_ARM);
  endfunction

  task automatic run_until(input string name, input int what, input int limit, output int cnt);
    int n;
    n = 0;
    cnt = 0;
    while (n < limit && !reached(what)) begin
      drive();
      cnt += int'(enable);
      step();
      n++;
    end
    chk({name, "_reached"}, int'(reached(what)), 1);
  endtask

  initial begin
    int cnt, n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_relay", relay_on, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_period", period, 0);
    chk("rst_valid", period_valid, 0);
    rst = 1'b0;

    vecs[0] = '{20, 20, 1};
    vecs[1] = '{25, 25, 0};
    vecs[2] = '{18, 18, 1};
    vecs[3] = '{17, 17, 0};
    vecs[4] = '{22, 22, 1};
    vecs[5] = '{23, 23, 0};
    en_all = 1'b1;
    foreach (vecs[i]) begin
      new_phase(vecs[i].per);
      repeat (4 * vecs[i].per) begin
        drive();
        step();
      end
      chk("tbl_period", period, vecs[i].exp_period);
      chk("tbl_valid", period_valid, vecs[i].exp_valid);
      chk("tbl_relay", relay_on, 0);
    end
    en_all = 1'b0;

    new_phase(20);
    run_until("arm", 3, 300, cnt);
    cnt = 0;
    while (cnt < 1500) begin
      drive();
      cnt += int'(enable);
      step();
    end
    drive();
    missing = 1'b1;
    step();
    missing = 1'b0;
    chk("abort_relay", relay_on, 0);
    chk("abort_fault", fault, 0);
    chk("abort_code", fault_code, 0);

    n = 0;
    cnt = 0;
    while (!relay_on && n < 8000) begin
      drive();
      cnt += (m_healthy() != 0 && enable) ? 1 : 0;
      step();
      n++;
    end
    chk("on_delay_ticks", cnt, ON_DLY);

    drive();
    missing = 1'b1;
    cnt = int'(enable);
    step();
    missing = 1'b0;
    chk("miss_relay", relay_on, 0);
    chk("miss_fault", fault, 1);
    chk("miss_code", fault_code, 1);
    run_until("miss_lock", 0, 12000, n);
    chk("lock_ticks", cnt + n, RESTART_DLY);
    run_until("miss_rearm", 1, 8000, cnt);
    chk("rearm_ticks", cnt, ON_DLY);

`ifdef PHASE_ROT_CHECK_EN
    drive();
    rotation = 1'b1;
    step();
    rotation = 1'b0;
    chk("rot_relay", relay_on, 0);
    chk("rot_fault", fault, 1);
    chk("rot_code", fault_code, 3);
    run_until("rot_lock", 0, 12000, cnt);
    run_until("rot_rearm", 1, 8000, cnt);
`else
    rotation = 1'b1;
    repeat (50) begin
      drive();
      step();
    end
    rotation = 1'b0;
    chk("rot_relay", relay_on, 1);
    chk("rot_fault", fault, 0);
`endif

    new_phase(17);
    run_until("freq", 2, 300, cnt);
    chk("freq_code", fault_code, 2);
    chk("freq_valid", period_valid, 0);
    chk("freq_relay", relay_on, 0);
    new_phase(20);
    run_until("freq_lock", 0, 12000, cnt);
    run_until("freq_rearm", 1, 8000, cnt);

    new_phase(0);
    run_until("stall", 2, 300, cnt);
    chk("stall_code", fault_code, 2);
    chk("stall_period", period, 20);
    chk("stall_valid", period_valid, 0);
    new_phase(20);
    run_until("stall_lock", 0, 12000, cnt);
    run_until("stall_rearm", 1, 8000, cnt);

    @(negedge clk);
    chk("pre_rst_relay", relay_on, 1);
    rst = 1'b1;
    #1;
    chk("arst_relay", relay_on, 0);
    chk("arst_fault", fault, 0);
    chk("arst_code", fault_code, 0);
    chk("arst_period", period, 0);
    chk("arst_valid", period_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 6000; i++) begin
      drive();
      if ($urandom_range(499, 0) == 0) new_phase(int'($urandom_range(24, 16)));
      missing = ($urandom_range(1999, 0) == 0);
      if ($urandom_range(2999, 0) == 0) rotation = ~rotation;
      step();
    end
    missing = 1'b0;
    rotation = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
